// File: rtl/wb_axil_bridge.sv
// Wishbone classic slave to AXI4-Lite master bridge: one WB access becomes one
// AXI-Lite write (AW+W) or read (AR+R), with a response timeout that forces an ack.
module wb_axil_bridge #(
  parameter int unsigned           ADDR_WIDTH = 12,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           TIMEOUT    = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [DATA_WIDTH-1:0] wbs_dat_i,
  input  logic [31:0]           wbs_adr_i,
  output logic                  wbs_ack_o,
  output logic [DATA_WIDTH-1:0] wbs_dat_o,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  timeout_o
);

  localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] TMO_CNT = CW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_DATA, ACK} state_e;

  state_e                state_q, state_d, fin_state;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  abort_q, abort_d;
  logic                  tmo_q, tmo_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
  logic                  req, busy, tmo;
  logic                  unused_adr;

  assign unused_adr = ^wbs_adr_i[31:ADDR_WIDTH];

  assign req  = wbs_stb_i & wbs_cyc_i;
  assign busy = (state_q == WRITE) || (state_q == RD_ADDR) || (state_q == RD_DATA);
  assign tmo  = busy && (cnt_q == TMO_CNT);
  // A master that dropped its request gets no ack; the AXI side still finishes.
  assign fin_state = (abort_q || !req) ? IDLE : ACK;

  assign awvalid   = (state_q == WRITE) && !aw_done_q && !tmo;
  assign wvalid    = (state_q == WRITE) && !w_done_q && !tmo;
  assign arvalid   = (state_q == RD_ADDR) && !tmo;
  assign rready    = (state_q == RD_DATA) && !tmo;
  assign wbs_ack_o = (state_q == ACK);
  assign timeout_o = tmo_q;
  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign wdata     = wdata_q;
  assign wbs_dat_o = rdat_q;

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    abort_d   = abort_q;
    tmo_d     = 1'b0;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdat_d    = rdat_q;
    if (busy) begin
      cnt_d = cnt_q + CW'(1);
      if (!req) abort_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d    = wbs_adr_i[ADDR_WIDTH-1:0];
          cnt_d     = '0;
          abort_d   = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (wbs_we_i) begin
            wdata_d = wbs_dat_i;
            state_d = (wbs_sel_i == 4'hF) ? WRITE : ACK;
          end else begin
            state_d = RD_ADDR;
          end
        end
      end
      WRITE: begin
        if (tmo) begin
          tmo_d   = 1'b1;
          state_d = fin_state;
        end else begin
          aw_done_d = aw_done_q | awready;
          w_done_d  = w_done_q | wready;
          if (aw_done_d && w_done_d) state_d = fin_state;
        end
      end
      RD_ADDR: begin
        if (tmo) begin
          tmo_d   = 1'b1;
          rdat_d  = ERR_DATA;
          state_d = fin_state;
        end else if (arready) begin
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (tmo) begin
          tmo_d   = 1'b1;
          rdat_d  = ERR_DATA;
          state_d = fin_state;
        end else if (rvalid) begin
          rdat_d  = rdata;
          state_d = fin_state;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      abort_q   <= 1'b0;
      tmo_q     <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdat_q    <= '0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      abort_q   <= abort_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdat_q    <= rdat_d;
    end
  end

endmodule

// File: tb/tb_wb_axil_bridge.sv
// Table-driven bench for wb_axil_bridge with a delay-programmable AXI-Lite slave model.
module tb_wb_axil_bridge;

  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] wdat_i, adr;
  logic        ack;
  logic [31:0] dat_o;
  logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [11:0] awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic        timeout;

  wb_axil_bridge #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT(16), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(wdat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdat;
    int          aw_dly, w_dly, ar_dly, r_dly;
    logic [31:0] rdat;
    int          exp_cyc;
    logic [31:0] exp_dat;
    int          exp_tmo, exp_awvc, exp_wvc, exp_arvc;
    bit          chk_addr;
    logic [11:0] exp_addr;
    bit          chk_wd;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[8];

  int passed = 0;
  int total  = 0;

  // slave model state
  int          aw_dly, w_dly, ar_dly, r_dly;
  int          aw_cnt, w_cnt, ar_cnt, r_cnt;
  int          aw_vc, w_vc, ar_vc, r_hs, tmo_cnt;
  logic [31:0] r_dat;
  logic [11:0] seen_addr;
  logic [31:0] seen_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic arm(input int a, input int w, input int ar, input int r, input logic [31:0] rd);
    aw_dly = a; w_dly = w; ar_dly = ar; r_dly = r; r_dat = rd;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
    aw_vc = 0; w_vc = 0; ar_vc = 0; r_hs = 0; tmo_cnt = 0;
  endtask

  // One cycle: advance to the falling edge, then respond as the AXI slave and monitor.
  task automatic tick();
    @(negedge clk);
    if (awvalid) begin
      awready = (aw_cnt == aw_dly); aw_cnt++; aw_vc++;
      if (awready) seen_addr = awaddr;
    end else awready = 1'b0;
    if (wvalid) begin
      wready = (w_cnt == w_dly); w_cnt++; w_vc++;
      if (wready) seen_wd = wdata;
    end else wready = 1'b0;
    if (arvalid) begin
      arready = (ar_cnt == ar_dly); ar_cnt++; ar_vc++;
      if (arready) seen_addr = araddr;
    end else arready = 1'b0;
    if (rready) begin
      rvalid = (r_cnt == r_dly); r_cnt++;
      rdata  = rvalid ? r_dat : '0;
      if (rvalid) r_hs++;
    end else begin
      rvalid = 1'b0; rdata = '0;
    end
    if (timeout) tmo_cnt++;
  endtask

  task automatic run_txn(input vec_t v, output int cyc_n, output logic [31:0] d, output logic ack_next);
    arm(v.aw_dly, v.w_dly, v.ar_dly, v.r_dly, v.rdat);
    we = v.we; sel = v.sel; adr = v.adr; wdat_i = v.wdat;
    stb = 1'b1; cyc = 1'b1;
    cyc_n = 0; d = 'x;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (ack) begin
        cyc_n = k + 1; d = dat_o;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    tick();
    ack_next = ack;
  endtask

  int          c;
  logic [31:0] d;
  logic        an;
  int          acks;

  initial begin
    //          we  sel    adr            wdat           aw w      ar r      rdat           cyc dat            tmo awvc wvc arvc ca addr     cw wd
    vecs[0] = '{1'b1, 4'hF, 32'h3000_0010, 32'h0000_0040, 0, 0,     0, 0,     32'h0,         3,  32'h0,         0, 1, 1,  0, 1'b1, 12'h010, 1'b1, 32'h0000_0040};
    vecs[1] = '{1'b1, 4'hF, 32'h3000_0024, 32'h1234_5678, 0, 5,     0, 0,     32'h0,         8,  32'h0,         0, 1, 6,  0, 1'b1, 12'h024, 1'b1, 32'h1234_5678};
    vecs[2] = '{1'b1, 4'hF, 32'h3000_0008, 32'hA5A5_0001, 3, 0,     0, 0,     32'h0,         6,  32'h0,         0, 4, 1,  0, 1'b1, 12'h008, 1'b1, 32'hA5A5_0001};
    vecs[3] = '{1'b0, 4'hF, 32'h3000_0000, 32'h0,         0, 0,     2, 3,     32'h0000_0004, 9,  32'h0000_0004, 0, 0, 0,  3, 1'b1, 12'h000, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 4'hF, 32'h3000_007C, 32'h0,         0, 0,     0, 0,     32'hCAFE_F00D, 4,  32'hCAFE_F00D, 0, 0, 0,  1, 1'b1, 12'h07C, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 4'hF, 32'h3000_0030, 32'h0,         0, 0,     0, NEVER, 32'h1111_1111, 19, 32'hDEAD_BEEF, 1, 0, 0,  1, 1'b1, 12'h030, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 4'h3, 32'h3000_0014, 32'h5555_AAAA, 0, 0,     0, 0,     32'h0,         2,  32'hDEAD_BEEF, 0, 0, 0,  0, 1'b0, 12'h000, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 4'hF, 32'h3000_0044, 32'h0BAD_0BAD, 0, NEVER, 0, 0,     32'h0,         19, 32'hDEAD_BEEF, 1, 1, 16, 0, 1'b1, 12'h044, 1'b0, 32'h0};

    rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = '0; wdat_i = '0; adr = '0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0;
    seen_addr = '0; seen_wd = '0;
    arm(0, 0, 0, 0, '0);
    repeat (3) @(negedge clk);
    chk("reset_ack", {31'b0, ack}, 32'h0);
    chk("reset_valids", {28'b0, awvalid, wvalid, arvalid, rready}, 32'h0);
    chk("reset_dat", dat_o, 32'h0);
    chk("reset_addr", {8'b0, awaddr, araddr}, 32'h0);
    chk("reset_wdata_tmo", wdata | {31'b0, timeout}, 32'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i], c, d, an);
      chk($sformatf("v%0d_ack_cycle", i), 32'(c), 32'(vecs[i].exp_cyc));
      chk($sformatf("v%0d_dat", i), d, vecs[i].exp_dat);
      chk($sformatf("v%0d_ack_one_cycle", i), {31'b0, an}, 32'h0);
      chk($sformatf("v%0d_timeout_pulses", i), 32'(tmo_cnt), 32'(vecs[i].exp_tmo));
      chk($sformatf("v%0d_awvalid_cycles", i), 32'(aw_vc), 32'(vecs[i].exp_awvc));
      chk($sformatf("v%0d_wvalid_cycles", i), 32'(w_vc), 32'(vecs[i].exp_wvc));
      chk($sformatf("v%0d_arvalid_cycles", i), 32'(ar_vc), 32'(vecs[i].exp_arvc));
      if (vecs[i].chk_addr) chk($sformatf("v%0d_axi_addr", i), {20'b0, seen_addr}, {20'b0, vecs[i].exp_addr});
      if (vecs[i].chk_wd) chk($sformatf("v%0d_axi_wdata", i), seen_wd, vecs[i].exp_wd);
    end

    // Abort: master drops stb during RD_DATA; no ack, but the R handshake still happens.
    arm(0, 0, 0, 4, 32'h0000_0077);
    we = 1'b0; sel = 4'hF; adr = 32'h3000_0020; stb = 1'b1; cyc = 1'b1;
    tick(); tick();
    stb = 1'b0; cyc = 1'b0;
    acks = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (ack) acks++;
    end
    chk("abort_no_ack", 32'(acks), 32'h0);
    chk("abort_r_handshake", 32'(r_hs), 32'h1);
    run_txn(vecs[0], c, d, an);
    chk("after_abort_write_cycle", 32'(c), 32'd3);
    chk("after_abort_wdata", seen_wd, 32'h0000_0040);

    // Reset asserted while waiting in RD_DATA.
    arm(0, 0, 0, NEVER, 32'h0);
    we = 1'b0; sel = 4'hF; adr = 32'h3000_0040; stb = 1'b1; cyc = 1'b1;
    repeat (5) tick();
    chk("pre_reset_rready", {31'b0, rready}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midreset_valids", {28'b0, awvalid, wvalid, arvalid, rready}, 32'h0);
    chk("midreset_ack_tmo", {30'b0, ack, timeout}, 32'h0);
    chk("midreset_dat", dat_o, 32'h0);
    chk("midreset_araddr", {20'b0, araddr}, 32'h0);
    stb = 1'b0; cyc = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    run_txn(vecs[4], c, d, an);
    chk("post_reset_read_cycle", 32'(c), 32'd4);
    chk("post_reset_read_dat", d, 32'hCAFE_F00D);
    chk("post_reset_araddr", {20'b0, seen_addr}, 32'h07C);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
